uart_tx: RTL and testbench

- Byte-wide UART transmitter (8N1 by default).
- Serialises a parallel byte onto a single line at a rate set by an external one-cycle baud_tick strobe.
- Sits between the host/control logic (start/ready handshake) and the TX pin.
- Baud-rate generation lives outside the block.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-wide UART transmitter.
// The optional parity stage is enabled by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   DEF_DATA_BITS = 8;
    localparam int   DEF_STOP_BITS = 1;
    localparam logic LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side start/ready handshake for the UART transmitter.
// The host is the master; the transmitter is the slave.
`timescale 1ns/1ps

interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();

    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (
        output start,
        output data,
        input  ready
    );

    modport slave (
        input  start,
        input  data,
        output ready
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises one DATA_BITS-wide word per accepted start, LSB first,
// with bit timing from an external baud_tick strobe. Define UART_TX_PARITY_EN for even parity.
`timescale 1ns/1ps

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     baud_tick,
    uart_tx_if.slave host,
    output logic     tx
);

    localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     bitCnt_q;
    logic                 stopCnt_q;
    logic                 tx_q;
    logic                 ready_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign tx         = tx_q;
    assign host.ready = ready_q;

    // Every line transition happens on a baud_tick edge, so the frame stays on the tick grid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            tx_q      <= LINE_IDLE;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= LINE_IDLE;
                    if (host.start) begin
                        shift_q  <= host.data;
                        ready_q  <= 1'b0;
                        state_q  <= ARM;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^host.data;
`endif
                    end
                end

                ARM: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        tx_q     <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bitCnt_q <= '0;
                        state_q  <= DATA;
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (bitCnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx_q      <= parity_q;
                            state_q   <= PARITY;
`else
                            tx_q      <= LINE_IDLE;
                            stopCnt_q <= 1'b0;
                            state_q   <= STOP;
`endif
                        end else begin
                            tx_q     <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx_q      <= LINE_IDLE;
                        stopCnt_q <= 1'b0;
                        state_q   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (baud_tick) begin
                        if (stopCnt_q == LAST_STOP) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stopCnt_q <= stopCnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    tx_q    <= LINE_IDLE;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model checked every cycle, plus literal bit patterns.
// Build with UART_TX_PARITY_EN defined to exercise the parity frames.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int TICK_DIV  = 10;

`ifdef UART_TX_PARITY_EN
    localparam string PAT_55 = "01010101001";
    localparam string PAT_5B = "01101101011";
    localparam string PAT_E3 = "01100011111";
    localparam string PAT_3C = "00011110001";
    localparam string PAT_59 = "01001101001";
`else
    localparam string PAT_55 = "0101010101";
    localparam string PAT_5B = "0110110101";
    localparam string PAT_E3 = "0110001111";
    localparam string PAT_3C = "0001111001";
`endif

    logic clk      = 1'b1;
    logic rst      = 1'b0;
    logic baudTick = 1'b0;
    logic txLine;

    int checks   = 0;
    int errors   = 0;
    bit checkEn  = 1'b0;
    int tickPhase = 0;

    uart_tx_if #(.DATA_BITS(DATA_BITS)) hostIf ();

    uart_tx #(
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baudTick),
        .host     (hostIf),
        .tx       (txLine)
    );

    always #5 clk = ~clk;

    // One-clock tick every TICK_DIV clocks, changed just after the rising edge.
    always @(posedge clk) begin
        #1;
        baudTick  = (tickPhase == TICK_DIV - 1);
        tickPhase = (tickPhase + 1) % TICK_DIV;
    end

    // Line model: a frame is a list of bit values; the k-th tick after acceptance puts entry k-1 on the line.
    logic expTx    = 1'b1;
    logic expReady = 1'b1;
    bit   busy     = 1'b0;
    int   ticks    = 0;
    bit   frameBits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     = 1'b0;
            ticks    = 0;
            expTx    = 1'b1;
            expReady = 1'b1;
        end else if (!busy) begin
            if (hostIf.start === 1'b1) begin
                frameBits.delete();
                frameBits.push_back(1'b0);
                for (int i = 0; i < DATA_BITS; i++) frameBits.push_back(hostIf.data[i]);
`ifdef UART_TX_PARITY_EN
                frameBits.push_back(^hostIf.data);
`endif
                for (int i = 0; i < STOP_BITS; i++) frameBits.push_back(1'b1);
                busy     = 1'b1;
                ticks    = 0;
                expReady = 1'b0;
            end
        end else if (baudTick) begin
            ticks++;
            if (ticks > frameBits.size()) begin
                busy     = 1'b0;
                expTx    = 1'b1;
                expReady = 1'b1;
            end else begin
                expTx = frameBits[ticks-1];
            end
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model tx", txLine, expTx);
            checkOutput("model ready", hostIf.ready, expReady);
        end
    end

    task automatic applyStimulus(input logic [DATA_BITS-1:0] d);
        @(posedge clk);
        #1;
        hostIf.start = 1'b1;
        hostIf.data  = d;
        @(posedge clk);
        #1;
        hostIf.start = 1'b0;
        hostIf.data  = ~d;
    endtask

    task automatic waitTxLow(input string name, output bit ok);
        int n = 0;
        while (txLine !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s start bit: tx=%b after %0d cycles, required 0", name, txLine, n);
        end
    endtask

    // Samples each bit near the middle of its period and compares with a literal pattern.
    task automatic expectLine(input string pattern, input string name);
        bit ok;
        waitTxLow(name, ok);
        if (ok) begin
            repeat (TICK_DIV / 2) @(negedge clk);
            for (int i = 0; i < pattern.len(); i++) begin
                if (i > 0) repeat (TICK_DIV) @(negedge clk);
                checkOutput($sformatf("%s bit%0d", name, i), txLine, pattern[i] == "1");
            end
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (hostIf.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL %s ready timeout: ready=%b, required 1", name, hostIf.ready);
        end
    endtask

    initial begin
        bit ok;
        hostIf.start = 1'b0;
        hostIf.data  = '0;
        rst = 1'b1;
        @(posedge clk);
        checkEn = 1'b1;

        // Start pulsed while reset is held must be ignored.
        #2 hostIf.start = 1'b1;
        hostIf.data = 8'hA5;
        #10 hostIf.start = 1'b0;
        #13 rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idle tx", txLine, 1'b1);
        checkOutput("idle ready", hostIf.ready, 1'b1);

        $display("[TB] send 0x55");
        applyStimulus(8'h55);
        @(negedge clk);
        checkOutput("ready drop", hostIf.ready, 1'b0);
        expectLine(PAT_55, "f55");
        waitReady("f55");

        $display("[TB] send 0x5B then 0xE3 at arbitrary phase");
        repeat (3) @(posedge clk);
        applyStimulus(8'h5B);
        expectLine(PAT_5B, "f5B");
        waitReady("f5B");
        repeat (7) @(posedge clk);
        applyStimulus(8'hE3);
        expectLine(PAT_E3, "fE3");
        waitReady("fE3");

        $display("[TB] busy rejection");
        applyStimulus(8'h55);
        fork
            expectLine(PAT_55, "busy55");
            begin
                repeat (40) @(posedge clk);
                applyStimulus(8'h59);
                @(negedge clk);
                checkOutput("busy ready", hostIf.ready, 1'b0);
            end
        join
        waitReady("busy55");
        repeat (5) @(negedge clk);
        checkOutput("no queue ready", hostIf.ready, 1'b1);
        repeat (20) @(negedge clk);

        $display("[TB] back-to-back with start held");
        @(posedge clk);
        #1;
        hostIf.start = 1'b1;
        hostIf.data  = 8'hA5;
        @(posedge clk);
        #1 hostIf.data = 8'h3C;
        waitReady("b2bA5");
        @(posedge clk);
        #1 hostIf.start = 1'b0;
        @(negedge clk);
        checkOutput("b2b ready", hostIf.ready, 1'b0);
        expectLine(PAT_3C, "b2b3C");
        waitReady("b2b3C");

        $display("[TB] reset mid-frame");
        applyStimulus(8'hE3);
        waitTxLow("rstE3", ok);
        repeat (30) @(negedge clk);
        checkOutput("pre-reset tx", txLine, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async tx", txLine, 1'b1);
        checkOutput("async ready", hostIf.ready, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(8'h5B);
        expectLine(PAT_5B, "post-reset 5B");
        waitReady("post-reset 5B");

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h59);
        expectLine(PAT_59, "par59");
        waitReady("par59");
        applyStimulus(8'h5B);
        expectLine(PAT_5B, "par5B");
        waitReady("par5B");
`endif

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
